// File: rtl/jtframe_vtimer_cfg.sv
// Parametrised video timing generator: H/V counters, blanking, syncs, look-ahead
// render lines, optional interlaced field toggle and a line interrupt with acknowledge.
module jtframe_vtimer_cfg #(
  parameter int unsigned HW        = 9,
  parameter int unsigned VW        = 9,
  parameter int unsigned FCW       = 8,
  parameter int unsigned INTERLACE = 0,
  parameter int unsigned H_START   = 0,
  parameter int unsigned H_END     = 395,
  parameter int unsigned HB_START  = 0,
  parameter int unsigned HB_END    = 115,
  parameter int unsigned HS_START  = 30,
  parameter int unsigned HS_END    = 40,
  parameter int unsigned V_START   = 0,
  parameter int unsigned V_END     = 255,
  parameter int unsigned VB_START  = 239,
  parameter int unsigned VB_END    = 255,
  parameter int unsigned VS_START  = 244,
  parameter int unsigned VS_END    = 247
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pxl_cen,
  input  logic [VW-1:0]  irq_line,
  input  logic           irq_en,
  input  logic           irq_ack,
  output logic [HW-1:0]  H,
  output logic [VW-1:0]  vdump,
  output logic [VW-1:0]  vrender,
  output logic [VW-1:0]  vrender1,
  output logic           Hinit,
  output logic           Vinit,
  output logic           LHBL,
  output logic           LVBL,
  output logic           HS,
  output logic           VS,
  output logic           field,
  output logic [FCW-1:0] frame_cnt,
  output logic           irq
);

  localparam logic [HW-1:0] HStart   = HW'(H_START);
  localparam logic [HW-1:0] HEnd     = HW'(H_END);
  localparam logic [HW-1:0] HbStart  = HW'(HB_START);
  localparam logic [HW-1:0] HbEnd    = HW'(HB_END);
  localparam logic [HW-1:0] HsStart  = HW'(HS_START);
  localparam logic [HW-1:0] HsEnd    = HW'(HS_END);
  // Odd fields move the VS edges by half a line
  localparam logic [HW-1:0] VsColOdd = HW'(HS_START + (H_END - H_START + 1) / 2);
  localparam logic [VW-1:0] VStart   = VW'(V_START);
  localparam logic [VW-1:0] VStart1  = VW'(V_START + 1);
  localparam logic [VW-1:0] VStart2  = VW'(V_START + 2);
  localparam logic [VW-1:0] VEnd     = VW'(V_END);
  localparam logic [VW-1:0] VbStart  = VW'(VB_START);
  localparam logic [VW-1:0] VbEnd    = VW'(VB_END);
  localparam logic [VW-1:0] VsStart  = VW'(VS_START);
  localparam logic [VW-1:0] VsEnd    = VW'(VS_END);

  logic          h_end;
  logic          last_line;
  logic          irq_set;
  logic [VW-1:0] vrender1_nx;
  logic [HW-1:0] vs_col;

  always_comb begin
    h_end       = (H == HEnd);
    last_line   = (vdump == VEnd);
    vrender1_nx = (vrender1 == VEnd) ? VStart : vrender1 + VW'(1);
    vs_col      = (INTERLACE != 0 && field) ? VsColOdd : HsStart;
    irq_set     = pxl_cen && (H == HbStart) && (vdump == irq_line) && irq_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      H         <= HStart;
      vdump     <= VStart;
      vrender   <= VStart1;
      vrender1  <= VStart2;
      Hinit     <= 1'b0;
      Vinit     <= 1'b0;
      LHBL      <= 1'b0;
      LVBL      <= 1'b1;
      HS        <= 1'b0;
      VS        <= 1'b0;
      field     <= 1'b0;
      frame_cnt <= '0;
    end else if (pxl_cen) begin
      H     <= h_end ? HStart : H + HW'(1);
      Hinit <= h_end;
      if (h_end) begin
        vrender1 <= vrender1_nx;
        vrender  <= vrender1;
        vdump    <= vrender;
        Vinit    <= last_line;
        if (last_line) begin
          frame_cnt <= frame_cnt + FCW'(1);
          if (INTERLACE != 0) field <= ~field;
        end
      end
      // Falling edge wins when both columns coincide
      if (H == HbStart) LHBL <= 1'b0;
      else if (H == HbEnd) LHBL <= 1'b1;
      if (H == HbStart) begin
        if (vdump == VbStart) LVBL <= 1'b0;
        else if (vdump == VbEnd) LVBL <= 1'b1;
      end
      if (H == HsStart) HS <= 1'b1;
      else if (H == HsEnd) HS <= 1'b0;
      if (H == vs_col) begin
        if (vdump == VsStart) VS <= 1'b1;
        else if (vdump == VsEnd) VS <= 1'b0;
      end
    end
  end

  // A new request beats a simultaneous acknowledge
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else if (irq_set) irq <= 1'b1;
    else if (irq_ack) irq <= 1'b0;
  end

endmodule
